mult_seq_param: RTL and testbench

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_seq_step.sv | 18 +
 rtl/mult_seq_param.sv | 115 +++++++++++
 tb/tb_mult_seq_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared FSM state type and default operand width for the sequential multiplier.
package mult_pkg;

  localparam int MULT_DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_seq_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand, then advance
// the multiplicand (left) and the multiplier (right) by one bit. Pure combinational.
module mult_seq_step #(
  parameter int WIDTH = 6
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplier
);

  assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
  assign o_mcand  = i_mcand << 1;
  assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/mult_seq_param.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned per operation.
// Define MULT_SEQ_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier bits are zero.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic               is_signed,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_e        r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_valid;

  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_mcand_next;
  logic [WIDTH-1:0]   w_mplier_next;
  logic               w_last;

  // Magnitudes are taken as unsigned WIDTH-bit values, so the most-negative
  // operand maps to 2**(WIDTH-1) and its product stays exact.
  assign w_neg1 = is_signed & num1[WIDTH-1];
  assign w_neg2 = is_signed & num2[WIDTH-1];
  assign w_mag1 = w_neg1 ? (~num1 + {{(WIDTH-1){1'b0}}, 1'b1}) : num1;
  assign w_mag2 = w_neg2 ? (~num2 + {{(WIDTH-1){1'b0}}, 1'b1}) : num2;

  mult_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_next),
    .o_mcand  (w_mcand_next),
    .o_mplier (w_mplier_next)
  );

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_LAST) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == CNT_LAST);
`endif

  // in_ready is gated by rstn so it reads 0 during reset yet rises in the
  // very first cycle after release, without waiting for a clock edge.
  assign in_ready  = rstn & (r_state == IDLE);
  assign result    = r_result;
  assign out_valid = r_out_valid;

  // NOTE: every state register uses non-blocking assignment and is cleared by
  // the async reset, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= w_neg1 ^ w_neg2;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= w_mcand_next;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= r_neg ? (~w_acc_next + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param: WIDTH=6 and WIDTH=16 instances, latency,
// backpressure, mid-operation reset and back-to-back throughput.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rstn;

  logic [5:0]  a6, b6;
  logic        sg6, iv6, ir6, ov6, or6;
  logic [11:0] res6;

  logic [15:0] a16, b16;
  logic        sg16, iv16, ir16, ov16, or16;
  logic [31:0] res16;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_seq_param #(.WIDTH(6)) u_dut6 (
    .clk(clk), .rstn(rstn), .num1(a6), .num2(b6), .is_signed(sg6),
    .in_valid(iv6), .in_ready(ir6), .result(res6), .out_valid(ov6), .out_ready(or6)
  );

  mult_seq_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .num1(a16), .num2(b16), .is_signed(sg16),
    .in_valid(iv16), .in_ready(ir16), .result(res16), .out_valid(ov16), .out_ready(or16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges from the accept edge until out_valid is first seen high.
  function automatic int exp_edges(input int w, input logic [31:0] mplier_mag);
    int hi;
    hi = 0;
    for (int i = 0; i < w; i++) if (mplier_mag[i]) hi = i + 1;
`ifdef MULT_SEQ_EARLY_TERM_EN
    return (hi < 1) ? 1 : hi;
`else
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run6(input string tag, input logic [5:0] a, input logic [5:0] b,
                      input logic s, input logic [11:0] exp_res, input int exp_lat);
    int n;
    check({tag, "_in_ready"}, ir6, 1);
    a6 = a; b6 = b; sg6 = s; iv6 = 1'b1;
    step();
    iv6 = 1'b0; a6 = ~a; b6 = ~b; sg6 = ~s;
    n = 0;
    while (!ov6 && n < 200) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, res6, exp_res);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp_res, input int exp_lat);
    int n;
    check({tag, "_in_ready"}, ir16, 1);
    a16 = a; b16 = b; sg16 = s; iv16 = 1'b1;
    step();
    iv16 = 1'b0; a16 = ~a; b16 = ~b;
    n = 0;
    while (!ov16 && n < 200) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, res16, exp_res);
  endtask

  logic [5:0]  bb_a [3] = '{6'd21, 6'd5,  6'd63};
  logic [5:0]  bb_b [3] = '{6'd37, 6'd48, 6'd63};
  logic [11:0] bb_r [3] = '{12'h309, 12'h0F0, 12'hF81};

  initial begin
    int t_prev, t_now, n;
    rstn = 1'b0;
    a6 = '0; b6 = '0; sg6 = 1'b0; iv6 = 1'b0; or6 = 1'b1;
    a16 = '0; b16 = '0; sg16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    t_prev = 0;

    #1;
    check("rst_result", res6, 12'h000);
    check("rst_out_valid", ov6, 0);
    check("rst_in_ready", ir6, 0);
    repeat (3) step();
    check("rst_in_ready_held", ir6, 0);
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", ir6, 1);
    check("post_rst_in_ready16", ir16, 1);
    step();

    // Unsigned 30*49 = 1470; out_valid in cycle WIDTH+1 after accept.
    run6("u30x49", 6'b011110, 6'b110001, 1'b0, 12'h5BE, exp_edges(6, 49));
    step();
    check("hs_out_valid", ov6, 0);
    check("hs_in_ready", ir6, 1);
    check("hs_result_held", res6, 12'h5BE);

    run6("s_m2x3", 6'b111110, 6'b000011, 1'b1, 12'hFFA, exp_edges(6, 3));
    step();
    run6("s_m32xm32", 6'b100000, 6'b100000, 1'b1, 12'h400, exp_edges(6, 32));
    step();
    run6("u63x63", 6'd63, 6'd63, 1'b0, 12'hF81, exp_edges(6, 63));
    step();
    run6("s_31xm32", 6'd31, 6'b100000, 1'b1, 12'hC20, exp_edges(6, 32));
    step();

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    or6 = 1'b0;
    run6("bp_7x9", 6'd7, 6'd9, 1'b0, 12'h03F, exp_edges(6, 9));
    for (int i = 0; i < 5; i++) begin
      iv6 = i[0] ? 1'b0 : 1'b1;
      a6 = 6'd60 - 6'(i); b6 = 6'd2;
      step();
      check("bp_out_valid", ov6, 1);
      check("bp_result", res6, 12'h03F);
      check("bp_in_ready", ir6, 0);
    end
    iv6 = 1'b0;
    or6 = 1'b1;
    step();
    check("bp_release_valid", ov6, 0);
    check("bp_release_ready", ir6, 1);
    check("bp_release_result", res6, 12'h03F);
    repeat (8) step();
    check("bp_no_spurious", ov6, 0);

    // Reset three cycles into BUSY.
    a6 = 6'd13; b6 = 6'd11; iv6 = 1'b1;
    step();
    iv6 = 1'b0;
    repeat (3) step();
    check("mid_busy_in_ready", ir6, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", ov6, 0);
    check("mid_rst_result", res6, 12'h000);
    check("mid_rst_in_ready", ir6, 0);
    repeat (2) step();
    rstn = 1'b1;
    #1;
    check("mid_rst_release_ready", ir6, 1);
    step();
    run6("after_rst_5x7", 6'd5, 6'd7, 1'b0, 12'h023, exp_edges(6, 7));
    step();

    // WIDTH=16 instance.
    run16("w16_ffffx1", 16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, exp_edges(16, 1));
    step();
    check("w16_hs_valid", ov16, 0);
    run16("w16_s_min_sq", 16'h8000, 16'h8000, 1'b1, 32'h40000000, exp_edges(16, 32'h8000));
    step();

    // Back-to-back with in_valid held high: one op per WIDTH+2 edges.
    iv6 = 1'b1;
    or6 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a6 = bb_a[k]; b6 = bb_b[k]; sg6 = 1'b0;
      n = 0;
      while (!ir6 && n < 50) begin
        step();
        n++;
      end
      check("b2b_in_ready", ir6, 1);
      step();
      t_now = cyc;
      if (k > 0) check("b2b_period", t_now - t_prev, 8);
      t_prev = t_now;
      n = 0;
      while (!ov6 && n < 200) begin
        step();
        n++;
      end
      check("b2b_result", res6, bb_r[k]);
    end
    iv6 = 1'b0;
    step();
    check("b2b_end_valid", ov6, 0);
    repeat (8) step();
    check("b2b_no_duplicate", ov6, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
